// File: rtl/flex_queue_pkg.sv
// flex_queue_pkg: shared types and helpers for the flex_queue FIFO.
//   qmode_e    - flow-control mode selector (normal / pipe / bypass)
//   cnt_width  - bits needed to hold an occupancy of 0..depth
//   ptr_width  - bits needed to address entries 0..depth-1
package flex_queue_pkg;

  typedef enum logic [1:0] {
    QMODE_NORMAL = 2'd0,
    QMODE_PIPE   = 2'd1,
    QMODE_BYPASS = 2'd2
  } qmode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/queue_regfile.sv
// queue_regfile: 1-write / 1-read register array, WIDTH x DEPTH.
//   clk       in   write clock
//   wr_en_i   in   write strobe (synchronous)
//   wr_addr_i in   write address, 0..DEPTH-1
//   wr_data_i in   write data
//   rd_addr_i in   read address, 0..DEPTH-1
//   rd_data_o out  read data (combinational)
// Contents are never reset; the owner tracks which entries are valid.
module queue_regfile
  import flex_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        wr_en_i,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]            rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/flex_queue.sv
// flex_queue: WIDTH x DEPTH FIFO with val/rdy handshakes on both sides.
// MODE selects flow control: 0 normal, 1 pipe (full queue may enqueue
// while dequeuing), 2 bypass (empty queue forwards recv straight to send).
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   flush        in   synchronous discard of all entries
//   recv_msg/val in   enqueue data / valid
//   recv_rdy     out  enqueue ready
//   send_msg/val out  dequeue data / valid
//   send_rdy     in   dequeue ready
//   num_entries  out  current occupancy
//   almost_full  out  occupancy >= AF_THRESH
module flex_queue
  import flex_queue_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MODE      = 0,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            recv_msg,
  input  logic                        recv_val,
  output logic                        recv_rdy,
  output logic [WIDTH-1:0]            send_msg,
  output logic                        send_val,
  input  logic                        send_rdy,
  output logic [cnt_width(DEPTH)-1:0] num_entries,
  output logic                        almost_full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam bit IS_PIPE   = (MODE == int'(QMODE_PIPE));
  localparam bit IS_BYPASS = (MODE == int'(QMODE_BYPASS));

  if (DEPTH < 2) begin : g_bad_depth
    $error("flex_queue: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("flex_queue: AF_THRESH must be in 1..DEPTH");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("flex_queue: MODE must be 0, 1 or 2");
  end

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, enq, deq, bypass_thru, wr_en;
  logic [WIDTH-1:0] rd_data;

  // Pointers wrap explicitly so any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Handshake outputs. reset is folded in so the outputs drop as soon as
  // reset rises, without waiting for the registers to settle.
  always_comb begin
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = rd_data;
    if (!reset && !flush) begin
      recv_rdy = !full || (IS_PIPE && send_rdy);
      send_val = !empty || (IS_BYPASS && recv_val);
    end
    if (IS_BYPASS && empty) begin
      send_msg = recv_msg;
    end
  end

  assign enq = recv_val & recv_rdy;
  assign deq = send_val & send_rdy;

  // A bypassed message never touches storage or the pointers.
  assign bypass_thru = IS_BYPASS && empty && enq && deq;
  assign wr_en       = enq && !bypass_thru;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        tail_d = ptr_inc(tail_q);
      end
      if (deq && !bypass_thru) begin
        head_d = ptr_inc(head_q);
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign num_entries = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESH));

  queue_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(tail_q),
    .wr_data_i(recv_msg),
    .rd_addr_i(head_q),
    .rd_data_o(rd_data)
  );

endmodule

// File: tb/tb_flex_queue.sv
module tb_flex_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // normal-mode instance
  logic       n_flush = 0, n_recv_val = 0, n_send_rdy = 0;
  logic [7:0] n_recv_msg = 0;
  logic       n_recv_rdy, n_send_val, n_af;
  logic [7:0] n_send_msg;
  logic [2:0] n_num;
  // pipe-mode instance
  logic       p_flush = 0, p_recv_val = 0, p_send_rdy = 0;
  logic [7:0] p_recv_msg = 0;
  logic       p_recv_rdy, p_send_val, p_af;
  logic [7:0] p_send_msg;
  logic [2:0] p_num;
  // bypass-mode instance
  logic       b_flush = 0, b_recv_val = 0, b_send_rdy = 0;
  logic [7:0] b_recv_msg = 0;
  logic       b_recv_rdy, b_send_val, b_af;
  logic [7:0] b_send_msg;
  logic [2:0] b_num;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flex_queue #(.WIDTH(8), .DEPTH(5), .MODE(0)) u_norm (
    .clk(clk), .reset(reset), .flush(n_flush),
    .recv_msg(n_recv_msg), .recv_val(n_recv_val), .recv_rdy(n_recv_rdy),
    .send_msg(n_send_msg), .send_val(n_send_val), .send_rdy(n_send_rdy),
    .num_entries(n_num), .almost_full(n_af)
  );

  flex_queue #(.WIDTH(8), .DEPTH(5), .MODE(1)) u_pipe (
    .clk(clk), .reset(reset), .flush(p_flush),
    .recv_msg(p_recv_msg), .recv_val(p_recv_val), .recv_rdy(p_recv_rdy),
    .send_msg(p_send_msg), .send_val(p_send_val), .send_rdy(p_send_rdy),
    .num_entries(p_num), .almost_full(p_af)
  );

  flex_queue #(.WIDTH(8), .DEPTH(5), .MODE(2)) u_byp (
    .clk(clk), .reset(reset), .flush(b_flush),
    .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(b_send_rdy),
    .num_entries(b_num), .almost_full(b_af)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b_recv_val = 1'b1;
    b_recv_msg = 8'h99;
    step();
    step();
    n_checks++; if (n_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_n_rdy: got %b want 0", n_recv_rdy); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL rst_n_val: got %b want 0", n_send_val); end
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL rst_n_num: got %0d want 0", n_num); end
    n_checks++; if (n_af !== 1'b0) begin n_fail++; $display("FAIL rst_n_af: got %b want 0", n_af); end
    n_checks++; if (b_send_val !== 1'b0) begin n_fail++; $display("FAIL rst_b_val: got %b want 0", b_send_val); end
    n_checks++; if (p_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_p_rdy: got %b want 0", p_recv_rdy); end
    reset = 1'b0;
    #1;
    n_checks++; if (n_recv_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_rdy: got %b want 1", n_recv_rdy); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL post_rst_val: got %b want 0", n_send_val); end
    n_checks++; if (b_send_val !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_val: got %b want 1", b_send_val); end
    b_recv_val = 1'b0;
    $display("reset: released");
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      n_recv_val = 1'b1; n_recv_msg = 8'(8'h11 + i); n_send_rdy = 1'b0;
      #1;
      n_checks++; if (n_recv_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_rdy[%0d]: got %b want 1", i, n_recv_rdy); end
      n_checks++; if (n_num !== 3'(i)) begin n_fail++; $display("FAIL fill_num[%0d]: got %0d want %0d", i, n_num, i); end
      n_checks++; if (n_af !== (i >= 4)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, n_af, (i >= 4)); end
      $display("fill: enq %h", n_recv_msg);
      step();
    end
    n_recv_val = 1'b0;
    #1;
    n_checks++; if (n_num !== 3'd5) begin n_fail++; $display("FAIL full_num: got %0d want 5", n_num); end
    n_checks++; if (n_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy: got %b want 0", n_recv_rdy); end
    n_checks++; if (n_af !== 1'b1) begin n_fail++; $display("FAIL full_af: got %b want 1", n_af); end
    // full in normal mode refuses even with a dequeue in the same cycle
    n_recv_val = 1'b1; n_recv_msg = 8'hEE; n_send_rdy = 1'b1;
    #1;
    n_checks++; if (n_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL full_deq_rdy: got %b want 0", n_recv_rdy); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #1;
      n_checks++; if (n_send_val !== 1'b1) begin n_fail++; $display("FAIL drain_val[%0d]: got %b want 1", i, n_send_val); end
      n_checks++; if (n_send_msg !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL drain_msg[%0d]: got %h want %h", i, n_send_msg, 8'(8'h11 + i)); end
      $display("drain: deq %h", n_send_msg);
      step();
      n_recv_val = 1'b0;
    end
    #1;
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL drain_empty_val: got %b want 0", n_send_val); end
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL drain_empty_num: got %0d want 0", n_num); end
    n_send_rdy = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_msg;
    n_send_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_recv_val = 1'b1; n_recv_msg = 8'(8'h20 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      n_recv_val = 1'b1; n_recv_msg = 8'(8'h30 + i); n_send_rdy = 1'b1;
      exp_msg = (i < 2) ? 8'(8'h20 + i) : 8'(8'h30 + i - 2);
      #1;
      n_checks++; if (n_send_msg !== exp_msg) begin n_fail++; $display("FAIL wrap_msg[%0d]: got %h want %h", i, n_send_msg, exp_msg); end
      n_checks++; if (n_num !== 3'd2) begin n_fail++; $display("FAIL wrap_num[%0d]: got %0d want 2", i, n_num); end
      $display("wrap: enq %h deq %h", n_recv_msg, n_send_msg);
      step();
    end
    n_recv_val = 1'b0;
    for (int i = 18; i < 20; i++) begin
      #1;
      n_checks++; if (n_send_msg !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, n_send_msg, 8'(8'h30 + i)); end
      step();
    end
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL wrap_end_num: got %0d want 0", n_num); end
    n_send_rdy = 1'b0;
  endtask

  task automatic test_pipe();
    p_send_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p_recv_val = 1'b1; p_recv_msg = 8'(8'h11 + i);
      step();
    end
    #1;
    n_checks++; if (p_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL pipe_full_rdy: got %b want 0", p_recv_rdy); end
    p_recv_msg = 8'hAA; p_send_rdy = 1'b1;
    #1;
    n_checks++; if (p_recv_rdy !== 1'b1) begin n_fail++; $display("FAIL pipe_full_deq_rdy: got %b want 1", p_recv_rdy); end
    n_checks++; if (p_send_msg !== 8'h11) begin n_fail++; $display("FAIL pipe_first: got %h want 11", p_send_msg); end
    $display("pipe: enq aa deq %h", p_send_msg);
    step();
    p_recv_val = 1'b0;
    #1;
    n_checks++; if (p_num !== 3'd5) begin n_fail++; $display("FAIL pipe_num: got %0d want 5", p_num); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #1;
      n_checks++; if (p_send_msg !== ((i < 4) ? 8'(8'h12 + i) : 8'hAA)) begin n_fail++; $display("FAIL pipe_drain[%0d]: got %h want %h", i, p_send_msg, ((i < 4) ? 8'(8'h12 + i) : 8'hAA)); end
      step();
    end
    n_checks++; if (p_send_val !== 1'b0) begin n_fail++; $display("FAIL pipe_empty: got %b want 0", p_send_val); end
    p_send_rdy = 1'b0;
  endtask

  task automatic test_bypass();
    b_recv_val = 1'b1; b_recv_msg = 8'h5C; b_send_rdy = 1'b1;
    #1;
    n_checks++; if (b_send_val !== 1'b1) begin n_fail++; $display("FAIL byp_val: got %b want 1", b_send_val); end
    n_checks++; if (b_send_msg !== 8'h5C) begin n_fail++; $display("FAIL byp_msg: got %h want 5c", b_send_msg); end
    $display("bypass: pass-through %h", b_send_msg);
    step();
    b_recv_val = 1'b0;
    #1;
    n_checks++; if (b_num !== 3'd0) begin n_fail++; $display("FAIL byp_num0: got %0d want 0", b_num); end
    b_recv_val = 1'b1; b_send_rdy = 1'b0;
    step();
    b_recv_val = 1'b1; b_recv_msg = 8'h77; b_send_rdy = 1'b1;
    #1;
    n_checks++; if (b_num !== 3'd1) begin n_fail++; $display("FAIL byp_num1: got %0d want 1", b_num); end
    n_checks++; if (b_send_msg !== 8'h5C) begin n_fail++; $display("FAIL byp_stored: got %h want 5c", b_send_msg); end
    step();
    b_recv_val = 1'b0;
    #1;
    n_checks++; if (b_send_msg !== 8'h77) begin n_fail++; $display("FAIL byp_second: got %h want 77", b_send_msg); end
    n_checks++; if (b_num !== 3'd1) begin n_fail++; $display("FAIL byp_num_hold: got %0d want 1", b_num); end
    step();
    n_checks++; if (b_num !== 3'd0) begin n_fail++; $display("FAIL byp_num_end: got %0d want 0", b_num); end
    b_send_rdy = 1'b0;
  endtask

  task automatic test_flush();
    n_send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_recv_val = 1'b1; n_recv_msg = 8'(8'h41 + i);
      step();
    end
    n_flush = 1'b1; n_send_rdy = 1'b1;
    b_flush = 1'b1; b_recv_val = 1'b1; b_recv_msg = 8'h66;
    #1;
    n_checks++; if (n_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rdy: got %b want 0", n_recv_rdy); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL flush_val: got %b want 0", n_send_val); end
    n_checks++; if (b_send_val !== 1'b0) begin n_fail++; $display("FAIL flush_b_val: got %b want 0", b_send_val); end
    step();
    n_flush = 1'b0; n_recv_val = 1'b0; b_flush = 1'b0; b_recv_val = 1'b0;
    #1;
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL flush_num: got %0d want 0", n_num); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL flush_after_val: got %b want 0", n_send_val); end
    n_checks++; if (b_num !== 3'd0) begin n_fail++; $display("FAIL flush_b_num: got %0d want 0", b_num); end
    $display("flush: done");
    n_send_rdy = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      n_recv_val = 1'b1; n_recv_msg = 8'(8'h51 + i);
      step();
    end
    n_checks++; if (n_num !== 3'd4) begin n_fail++; $display("FAIL areset_pre_num: got %0d want 4", n_num); end
    n_send_rdy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL areset_num: got %0d want 0", n_num); end
    n_checks++; if (n_recv_rdy !== 1'b0) begin n_fail++; $display("FAIL areset_rdy: got %b want 0", n_recv_rdy); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL areset_val: got %b want 0", n_send_val); end
    n_checks++; if (n_af !== 1'b0) begin n_fail++; $display("FAIL areset_af: got %b want 0", n_af); end
    step();
    n_recv_val = 1'b0; n_send_rdy = 1'b0;
    #2;
    reset = 1'b0;
    step();
    n_checks++; if (n_num !== 3'd0) begin n_fail++; $display("FAIL areset_after_num: got %0d want 0", n_num); end
    n_checks++; if (n_send_val !== 1'b0) begin n_fail++; $display("FAIL areset_after_val: got %b want 0", n_send_val); end
    n_checks++; if (n_recv_rdy !== 1'b1) begin n_fail++; $display("FAIL areset_after_rdy: got %b want 1", n_recv_rdy); end
    $display("async reset: done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_pipe();
    test_bypass();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
